// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad column scanner with debounce, hex key strobe
// and a 4-digit BCD entry register that feeds the 7-segment display driver.
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [3:0] units,
    output logic [3:0] tens,
    output logic [3:0] hundreds,
    output logic [3:0] thousands
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [3:0] DS = 4'(DEBOUNCE_SCANS);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] PRESSED  = 2'd2;
    // nibble index is {row, col}
    localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

    logic [3:0]    row_meta, row_sync;
    logic [PW-1:0] presc;
    logic [1:0]    col_idx, next_col, low_row, state;
    logic          sample, scan_end, col_hit, found, res_valid, accept, release_done;
    logic [3:0]    col_code, found_code, res_code, cand, count, count_inc;

    always_comb begin
        sample       = presc == PRESC_MAX;
        scan_end     = sample && col_idx == 2'd3;
        next_col     = col_idx + 2'd1;
        col_hit      = row_sync != 4'hF;
        low_row      = !row_sync[0] ? 2'd0 : !row_sync[1] ? 2'd1 : !row_sync[2] ? 2'd2 : 2'd3;
        col_code     = KEY_MAP[{low_row, col_idx, 2'b00} +: 4];
        res_valid    = found || col_hit;
        res_code     = found ? found_code : col_code;
        count_inc    = (count < DS) ? count + 4'd1 : count;
        accept       = scan_end && res_valid &&
                       (state == IDLE ? DS == 4'd1 :
                        state == DEBOUNCE && res_code == cand && count_inc == DS);
        release_done = scan_end && state == PRESSED && !res_valid && count_inc == DS;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row_n;
            row_sync <= row_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc   <= '0;
            col_idx <= 2'd0;
            col_n   <= 4'b1110;
        end else begin
            presc <= sample ? '0 : presc + 1'b1;
            if (sample) begin
                col_idx <= next_col;
                col_n   <= ~(4'b0001 << next_col);
            end
        end
    end

    // First hit of the scan is latched; later keys in the same scan are ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            found      <= 1'b0;
            found_code <= 4'd0;
        end else if (sample) begin
            if (col_idx == 2'd3) begin
                found <= 1'b0;
            end else if (!found && col_hit) begin
                found      <= 1'b1;
                found_code <= col_code;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cand  <= 4'd0;
            count <= 4'd0;
        end else if (scan_end) begin
            case (state)
                IDLE: if (res_valid) begin
                    cand  <= res_code;
                    count <= accept ? 4'd0 : 4'd1;
                    state <= accept ? PRESSED : DEBOUNCE;
                end
                DEBOUNCE: if (!res_valid) begin
                    state <= IDLE;
                    count <= 4'd0;
                end else if (res_code != cand) begin
                    cand  <= res_code;
                    count <= 4'd1;
                end else if (accept) begin
                    state <= PRESSED;
                    count <= 4'd0;
                end else begin
                    count <= count_inc;
                end
                PRESSED: if (res_valid) begin
                    count <= 4'd0;
                end else if (release_done) begin
                    state <= IDLE;
                    count <= 4'd0;
                end else begin
                    count <= count_inc;
                end
                default: begin
                    state <= IDLE;
                    count <= 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            units     <= 4'd0;
            tens      <= 4'd0;
            hundreds  <= 4'd0;
            thousands <= 4'd0;
        end else begin
            key_valid <= accept;
            key_held  <= accept ? 1'b1 : release_done ? 1'b0 : key_held;
            if (accept) begin
                key_code <= res_code;
                if (res_code <= 4'd9) begin
                    thousands <= hundreds;
                    hundreds  <= tens;
                    tens      <= units;
                    units     <= res_code;
                end else if (res_code == 4'hC) begin
                    thousands <= 4'd0;
                    hundreds  <= 4'd0;
                    tens      <= 4'd0;
                    units     <= 4'd0;
                end
            end
        end
    end

endmodule
